// File: rtl/sc_median_ctrl.sv
// Stochastic-computing 3x3 median sequencer: turns a binary window into nine
// correlated bitstreams, drives the external median network for one LFSR period, and counts the result.
module sc_median_ctrl #(
  parameter int          DATA_W    = 8,
  parameter int unsigned LFSR_SEED = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [9*DATA_W-1:0]   in_pix,
  input  logic                  flush,
  output logic [8:0]            sc_window,
  output logic                  sc_valid,
  input  logic                  sc_result,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_pix,
  output logic                  busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [DATA_W-1:0] SEED = DATA_W'(LFSR_SEED);
  // Last RUN cycle index: L-1 = 2^DATA_W - 2
  localparam logic [DATA_W-1:0] LAST_CYC = {{(DATA_W-1){1'b1}}, 1'b0};

  function automatic logic [DATA_W-1:0] tap_mask();
    logic [7:0] m;
    case (DATA_W)
      4:       m = 8'h0C;
      5:       m = 8'h14;
      6:       m = 8'h30;
      7:       m = 8'h60;
      default: m = 8'hB8;
    endcase
    return m[DATA_W-1:0];
  endfunction

  localparam logic [DATA_W-1:0] TAP_MASK = tap_mask();

  logic [1:0]        r_state;
  logic              r_init;
  logic [DATA_W-1:0] r_lfsr;
  logic [DATA_W-1:0] r_cyc;
  logic [DATA_W-1:0] r_ones;
  logic [DATA_W-1:0] r_pix [9];
  logic              w_run;
  logic              w_accept;
  logic              w_fb;

  assign w_run     = (r_state == S_RUN);
  // r_init keeps in_ready low during reset without a path from in_valid
  assign in_ready  = r_init && (r_state == S_IDLE);
  assign w_accept  = in_ready && in_valid && !flush;
  assign w_fb      = ^(r_lfsr & TAP_MASK);
  assign sc_valid  = w_run;
  assign out_valid = (r_state == S_DONE);
  assign out_pix   = out_valid ? r_ones : '0;
  assign busy      = (r_state != S_IDLE);

  // All nine comparators share one LFSR value, giving nested streams
  always_comb begin
    sc_window = '0;
    for (int k = 0; k < 9; k++) begin
      sc_window[k] = w_run && (r_pix[k] >= r_lfsr);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_init  <= 1'b0;
      r_lfsr  <= SEED;
      r_cyc   <= '0;
      r_ones  <= '0;
    end else begin
      r_init <= 1'b1;
      if (flush) begin
        r_state <= S_IDLE;
        r_lfsr  <= SEED;
        r_cyc   <= '0;
        r_ones  <= '0;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_accept) begin
              r_state <= S_RUN;
              r_lfsr  <= SEED;
              r_cyc   <= '0;
              r_ones  <= '0;
            end
          end
          S_RUN: begin
            r_ones <= r_ones + {{(DATA_W-1){1'b0}}, sc_result};
            r_lfsr <= {r_lfsr[DATA_W-2:0], w_fb};
            r_cyc  <= r_cyc + 1'b1;
            if (r_cyc == LAST_CYC) r_state <= S_DONE;
          end
          S_DONE: begin
            if (out_ready) r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_accept) begin
      for (int k = 0; k < 9; k++) begin
        r_pix[k] <= in_pix[k*DATA_W +: DATA_W];
      end
    end
  end

endmodule

// File: tb/tb_sc_median_ctrl.sv
// Directed bench for sc_median_ctrl (DATA_W=8) with a behavioural 9-input majority as the median network.
module tb_sc_median_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] in_pix;
  logic        flush;
  logic [8:0]  sc_window;
  logic        sc_valid;
  logic        sc_result;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pix;
  logic        busy;

  int total = 0;
  int bad   = 0;

  int          px [9];
  int          ones [9];
  int          sv_cnt;
  int          lat;
  logic [7:0]  res;
  logic [8:0]  first_win;
  bit          to;

  sc_median_ctrl #(.DATA_W(8), .LFSR_SEED(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pix    (in_pix),
    .flush     (flush),
    .sc_window (sc_window),
    .sc_valid  (sc_valid),
    .sc_result (sc_result),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pix   (out_pix),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Median of nine nested unipolar bits is their majority
  assign sc_result = ($countones(sc_window) >= 5);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [71:0] pack(input int p [9]);
    logic [71:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[k*8 +: 8] = 8'(p[k]);
    return v;
  endfunction

  // Wait (bounded) for in_ready, then present the window for one accept edge
  task automatic send(input logic [71:0] w, output bit timeout);
    int n;
    n = 0;
    timeout = 0;
    in_pix = w;
    in_valid = 1'b1;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) timeout = 1;
    step();
    in_valid = 1'b0;
  endtask

  // Starts in RUN cycle 1; stops in the first cycle where out_valid is high
  task automatic run_to_done(output bit timeout);
    sv_cnt = 0;
    lat = 1;
    for (int k = 0; k < 9; k++) ones[k] = 0;
    first_win = sc_window;
    while (!out_valid && lat < 1000) begin
      if (sc_valid) sv_cnt++;
      for (int k = 0; k < 9; k++) ones[k] += int'(sc_window[k]);
      step();
      lat++;
    end
    timeout = !out_valid;
    res = out_pix;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1; in_pix = '0;
    step(); step();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b want=0", busy); end
    total++; if (sc_valid !== 1'b0 || sc_window !== 9'd0) begin bad++; $display("FAIL reset_sc got=%b/%b want=0/0", sc_valid, sc_window); end
    total++; if (out_valid !== 1'b0 || out_pix !== 8'd0) begin bad++; $display("FAIL reset_out got=%b/%0d want=0/0", out_valid, out_pix); end
    rst_n = 1'b1;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL release_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_uniform();
    for (int k = 0; k < 9; k++) px[k] = 100;
    send(pack(px), to);
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL uniform_in_ready_run got=%b want=0", in_ready); end
    run_to_done(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL uniform_timeout got=%b want=0", to); end
    total++; if (res !== 8'd100) begin bad++; $display("FAIL uniform_pix got=%0d want=100", res); end
    total++; if (lat !== 256) begin bad++; $display("FAIL uniform_latency got=%0d want=256", lat); end
    total++; if (sv_cnt !== 255) begin bad++; $display("FAIL uniform_sc_valid_cycles got=%0d want=255", sv_cnt); end
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL uniform_ready_after got=%b want=1", in_ready); end
  endtask

  task automatic test_exact_median();
    px = '{0, 255, 17, 200, 90, 3, 128, 64, 250};
    send(pack(px), to);
    run_to_done(to);
    total++; if (to !== 1'b0) begin bad++; $display("FAIL median_timeout got=%b want=0", to); end
    total++; if (res !== 8'd90) begin bad++; $display("FAIL median_pix got=%0d want=90", res); end
    for (int k = 0; k < 9; k++) begin
      total++;
      if (ones[k] !== px[k]) begin bad++; $display("FAIL median_stream_ones k=%0d got=%0d want=%0d", k, ones[k], px[k]); end
    end
    step();
  endtask

  task automatic test_extremes();
    for (int k = 0; k < 9; k++) px[k] = 0;
    send(pack(px), to); run_to_done(to);
    total++; if (res !== 8'd0 || to) begin bad++; $display("FAIL extreme_all0 got=%0d want=0", res); end
    step();
    for (int k = 0; k < 9; k++) px[k] = 255;
    send(pack(px), to); run_to_done(to);
    total++; if (res !== 8'd255 || to) begin bad++; $display("FAIL extreme_all255 got=%0d want=255", res); end
    step();
    px[4] = 0;
    send(pack(px), to); run_to_done(to);
    total++; if (res !== 8'd255 || to) begin bad++; $display("FAIL extreme_eight255 got=%0d want=255", res); end
    step();
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b0;
    px = '{5, 6, 7, 8, 9, 10, 11, 12, 13};
    send(pack(px), to);
    run_to_done(to);
    total++; if (res !== 8'd9 || to) begin bad++; $display("FAIL bp_first_pix got=%0d want=9", res); end
    px = '{30, 40, 50, 60, 70, 80, 90, 100, 110};
    in_pix = pack(px);
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      total++;
      if (out_valid !== 1'b1 || out_pix !== 8'd9 || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold i=%0d got ov=%b pix=%0d rdy=%b want ov=1 pix=9 rdy=0", i, out_valid, out_pix, in_ready);
      end
    end
    out_ready = 1'b1;
    step();
    total++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin bad++; $display("FAIL bp_release got rdy=%b ov=%b want rdy=1 ov=0", in_ready, out_valid); end
    step();
    in_valid = 1'b0;
    total++; if (busy !== 1'b1 || sc_valid !== 1'b1) begin bad++; $display("FAIL b2b_accept got busy=%b scv=%b want 1/1", busy, sc_valid); end
    run_to_done(to);
    total++; if (res !== 8'd70 || to) begin bad++; $display("FAIL b2b_second_pix got=%0d want=70", res); end
    total++; if (lat !== 256) begin bad++; $display("FAIL b2b_latency got=%0d want=256", lat); end
    step();
  endtask

  task automatic test_flush();
    bit seen_ov;
    px = '{77, 77, 77, 77, 77, 77, 77, 77, 77};
    in_pix = pack(px);
    in_valid = 1'b1;
    flush = 1'b1;
    step();
    in_valid = 1'b0;
    flush = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL flush_idle_accept got busy=%b want=0", busy); end
    send(pack(px), to);
    for (int i = 1; i < 50; i++) step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    total++; if (busy !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL flush_to_idle got busy=%b rdy=%b want 0/1", busy, in_ready); end
    total++; if (sc_window !== 9'd0 || sc_valid !== 1'b0) begin bad++; $display("FAIL flush_sc got win=%b scv=%b want 0/0", sc_window, sc_valid); end
    seen_ov = 0;
    for (int i = 0; i < 300; i++) begin
      if (out_valid) seen_ov = 1;
      step();
    end
    total++; if (seen_ov !== 1'b0) begin bad++; $display("FAIL flush_no_out got=%b want=0", seen_ov); end
    px = '{42, 42, 42, 10, 20, 30, 50, 60, 70};
    send(pack(px), to); run_to_done(to);
    total++; if (res !== 8'd42 || to) begin bad++; $display("FAIL flush_next_pix got=%0d want=42", res); end
    step();
  endtask

  task automatic test_reset_mid_run();
    px = '{0, 1, 2, 3, 4, 5, 6, 7, 8};
    send(pack(px), to);
    for (int i = 1; i < 100; i++) step();
    rst_n = 1'b0;
    step();
    total++; if (in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL rstrun_ctrl got rdy=%b busy=%b want 0/0", in_ready, busy); end
    total++; if (sc_window !== 9'd0 || sc_valid !== 1'b0) begin bad++; $display("FAIL rstrun_sc got win=%b scv=%b want 0/0", sc_window, sc_valid); end
    total++; if (out_valid !== 1'b0 || out_pix !== 8'd0) begin bad++; $display("FAIL rstrun_out got ov=%b pix=%0d want 0/0", out_valid, out_pix); end
    rst_n = 1'b1;
    step();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rstrun_release got=%b want=1", in_ready); end
    send(pack(px), to); run_to_done(to);
    // r = 1 in the first RUN cycle: every pixel >= 1 is set
    total++; if (first_win !== 9'b111111110) begin bad++; $display("FAIL rstrun_seed_window got=%b want=111111110", first_win); end
    total++; if (res !== 8'd4 || to) begin bad++; $display("FAIL rstrun_pix got=%0d want=4", res); end
    step();
  endtask

  initial begin
    test_reset();
    test_uniform();
    test_exact_median();
    test_extremes();
    test_back_to_back();
    test_flush();
    test_reset_mid_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
